text_layer_render: RTL and testbench

TEXT_LAYER_RENDER -- requirements
Module: text_layer_render

---
 rtl/text_layer_render.sv | 209 ++++++++++++++++++++
 tb/tb_text_layer_render.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/text_layer_render.sv
// -----------------------------------------------------------------------------
// text_layer_render
//
// Turns a stream of (pixel position, character, attribute) into RGBA pixels
// through a fixed 3-stage pipeline, one pixel per clock, no stalls:
//   S1  capture inputs, blink phase and (optionally) cursor hit
//   S2  synchronous font ROM read, address {char, glyph_row}
//   S3  blink / cursor handling and palette lookup into the output registers
//
// Optional feature macro: TEXT_CURSOR_EN (adds cursor ports and fg/bg swap on
// the cursor cell while the blink phase is high).
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   refresh               one-cycle frame-start pulse, advances the blink counter
//   pix_valid             qualifies x_pixel, y_pixel, cur_char, cur_attr
//   x_pixel, y_pixel      pixel coordinates
//   cur_char              character code of the cell holding the pixel
//   cur_attr              [3:0] fg index, [6:4] bg index, [7] blink enable
//   pal_we/addr/data      palette write port (16 entries)
//   cursor_on/col/row     cursor controls (TEXT_CURSOR_EN only)
//   rgba_out, out_valid   registered pixel colour and its qualifier
//
// Flow control: valid-only stream. pix_valid travels with its data and every
// stage advances every cycle; there is no ready/backpressure. out_valid is
// pix_valid delayed by 3 cycles and rgba_out only updates when out_valid=1.
// -----------------------------------------------------------------------------
module text_layer_render #(
  parameter int                 WIDTH      = 1024,
  parameter int                 HEIGHT     = 768,
  parameter int                 GLYPH_W    = 8,
  parameter int                 GLYPH_H    = 16,
  parameter int                 CHAR_WIDTH = 8,
  parameter int                 COLOR_W    = 32,
  parameter logic [COLOR_W-1:0] BKG_COLOR  = COLOR_W'(32'h000000FF),
  parameter logic [COLOR_W-1:0] TEXT_COLOR = COLOR_W'(32'hFFFFFFFF),
  parameter int                 BLINK_LOG2 = 5
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  refresh,
  input  logic                                  pix_valid,
  input  logic [$clog2(WIDTH)-1:0]              x_pixel,
  input  logic [$clog2(HEIGHT)-1:0]             y_pixel,
  input  logic [CHAR_WIDTH-1:0]                 cur_char,
  input  logic [7:0]                            cur_attr,
  input  logic                                  pal_we,
  input  logic [3:0]                            pal_addr,
  input  logic [COLOR_W-1:0]                    pal_data,
`ifdef TEXT_CURSOR_EN
  input  logic                                  cursor_on,
  input  logic [$clog2(WIDTH/GLYPH_W)-1:0]      cursor_col,
  input  logic [$clog2(HEIGHT/GLYPH_H)-1:0]     cursor_row,
`endif
  output logic [COLOR_W-1:0]                    rgba_out,
  output logic                                  out_valid
);

  localparam int X_W    = $clog2(WIDTH);
  localparam int Y_W    = $clog2(HEIGHT);
  localparam int GX_W   = $clog2(GLYPH_W);
  localparam int GY_W   = $clog2(GLYPH_H);
  localparam int ADDR_W = CHAR_WIDTH + GY_W;

  // ---------------------------------------------------------------------------
  // Font ROM contents. Procedural stand-in font: the row pattern is the low
  // GLYPH_W bits of the character code rotated left by the glyph row. The MSB
  // of a row is the leftmost pixel. Swap this function for a bitmap table to
  // ship a real font; the pipeline around it does not change.
  // ---------------------------------------------------------------------------
  function automatic logic [GLYPH_W-1:0] font_row(input logic [ADDR_W-1:0] addr);
    logic [GLYPH_W-1:0] base;
    int                 rot;
    base = GLYPH_W'(addr[ADDR_W-1:GY_W]);
    rot  = int'(addr[GY_W-1:0]) % GLYPH_W;
    return (base << rot) | (base >> (GLYPH_W - rot));
  endfunction

  // ---------------------------------------------------------------------------
  // Frame counter; its MSB is the blink phase.
  // ---------------------------------------------------------------------------
  logic [BLINK_LOG2-1:0] frame_cnt;
  logic                  blink_phase;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        frame_cnt <= '0;
    else if (refresh) frame_cnt <= frame_cnt + BLINK_LOG2'(1);
  end

  // Current (pre-increment) value, so a refresh in the same cycle as a pixel
  // only affects later pixels.
  assign blink_phase = frame_cnt[BLINK_LOG2-1];

  // ---------------------------------------------------------------------------
  // Palette: entry 0 is the background, 1..15 the text colour out of reset.
  // A write lands at the same edge S3 samples the palette, so the pixel in S3
  // that cycle still sees the old value.
  // ---------------------------------------------------------------------------
  logic [COLOR_W-1:0] palette [16];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) palette[i] <= (i == 0) ? BKG_COLOR : TEXT_COLOR;
    end else if (pal_we) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: input capture
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic [CHAR_WIDTH-1:0] s1_char;
  logic [GY_W-1:0]       s1_gy;
  logic [GX_W-1:0]       s1_gx;
  logic [7:0]            s1_attr;
  logic                  s1_blink;
  logic                  s1_cursor_hit;

`ifdef TEXT_CURSOR_EN
  localparam int COL_W = $clog2(WIDTH/GLYPH_W);
  localparam int ROW_W = $clog2(HEIGHT/GLYPH_H);

  logic [COL_W-1:0] cell_col;
  logic [ROW_W-1:0] cell_row;
  logic             cursor_hit;

  assign cell_col   = COL_W'(x_pixel >> GX_W);
  assign cell_row   = ROW_W'(y_pixel >> GY_W);
  assign cursor_hit = cursor_on && (cell_col == cursor_col) && (cell_row == cursor_row);
`else
  logic cursor_hit;
  logic unused_cell_bits;

  assign cursor_hit       = 1'b0;
  // Cell coordinates only matter to the cursor logic.
  assign unused_cell_bits = ^{x_pixel[X_W-1:GX_W], y_pixel[Y_W-1:GY_W]};
`endif

  // ---------------------------------------------------------------------------
  // S2: font ROM read
  // ---------------------------------------------------------------------------
  logic                  s2_valid;
  logic [GLYPH_W-1:0]    rom_data;
  logic [GX_W-1:0]       s2_gx;
  logic [7:0]            s2_attr;
  logic                  s2_blink;
  logic                  s2_cursor_hit;
  logic [ADDR_W-1:0]     font_addr;

  assign font_addr = {s1_char, s1_gy};

  // Only the valid bits need reset: data following an invalid bit is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= pix_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk) begin
    s1_char       <= cur_char;
    s1_gy         <= y_pixel[GY_W-1:0];
    s1_gx         <= x_pixel[GX_W-1:0];
    s1_attr       <= cur_attr;
    s1_blink      <= blink_phase;
    s1_cursor_hit <= cursor_hit;

    rom_data      <= font_row(font_addr);
    s2_gx         <= s1_gx;
    s2_attr       <= s1_attr;
    s2_blink      <= s1_blink;
    s2_cursor_hit <= s1_cursor_hit;
  end

  // ---------------------------------------------------------------------------
  // S3: pixel decision and palette lookup
  // ---------------------------------------------------------------------------
  logic [GX_W-1:0]    bit_idx;
  logic               glyph_bit;
  logic               pixel_bit;
  logic               swap;
  logic [COLOR_W-1:0] fg_color;
  logic [COLOR_W-1:0] bg_color;
  logic [COLOR_W-1:0] pix_color;

  always_comb begin
    bit_idx   = GX_W'(GLYPH_W - 1) - s2_gx;
    glyph_bit = rom_data[bit_idx];
    // Blinking characters vanish (show background) during the high phase.
    pixel_bit = glyph_bit & ~(s2_attr[7] & s2_blink);
    // Cursor swap applies after blinking: it inverts which colour is chosen.
    swap      = s2_cursor_hit & s2_blink;
    fg_color  = palette[s2_attr[3:0]];
    bg_color  = palette[{1'b0, s2_attr[6:4]}];
    pix_color = (pixel_bit ^ swap) ? fg_color : bg_color;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         rgba_out <= '0;
    else if (s2_valid) rgba_out <= pix_color;
  end

endmodule

// File: tb/tb_text_layer_render.sv
// -----------------------------------------------------------------------------
// tb_text_layer_render
//
// Directed bench for text_layer_render with default parameters. Each step
// drives one input cycle with a hand-computed expected colour; a 3-deep
// expected queue lines it up with the output. Reference font row used for
// the expectations: low 8 bits of the code rotated left by the glyph row
// (0x41: row0 = 0x41, row1 = 0x82, row2 = 0x05, row15 = 0xA0).
// -----------------------------------------------------------------------------
module tb_text_layer_render;

  localparam logic [31:0] BKG = 32'h000000FF;
  localparam logic [31:0] TXT = 32'hFFFFFFFF;
  localparam logic [31:0] RED = 32'hFF0000FF;
  localparam logic [31:0] C2  = 32'h11223344;
  localparam logic [31:0] C3  = 32'h55667788;

  // clock/reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  logic        refresh = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  x_pixel = '0;
  logic [9:0]  y_pixel = '0;
  logic [7:0]  cur_char = '0;
  logic [7:0]  cur_attr = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_addr = '0;
  logic [31:0] pal_data = '0;
`ifdef TEXT_CURSOR_EN
  logic        cursor_on = 1'b0;
  logic [6:0]  cursor_col = '0;
  logic [5:0]  cursor_row = '0;
`endif
  logic [31:0] rgba_out;
  logic        out_valid;

  text_layer_render dut (
    .clk       (clk),
    .reset     (reset),
    .refresh   (refresh),
    .pix_valid (pix_valid),
    .x_pixel   (x_pixel),
    .y_pixel   (y_pixel),
    .cur_char  (cur_char),
    .cur_attr  (cur_attr),
    .pal_we    (pal_we),
    .pal_addr  (pal_addr),
    .pal_data  (pal_data),
`ifdef TEXT_CURSOR_EN
    .cursor_on (cursor_on),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
`endif
    .rgba_out  (rgba_out),
    .out_valid (out_valid)
  );

  // scoreboard
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        exp_v_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] hold_color;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // Pipeline is empty after reset: the next two outputs are invalid.
  task automatic sb_reset();
    exp_v_q.delete();
    exp_q.delete();
    exp_v_q.push_back(1'b0); exp_q.push_back('0);
    exp_v_q.push_back(1'b0); exp_q.push_back('0);
    hold_color = '0;
  endtask

  // driver: one input cycle, then check the output that emerges
  task automatic step(input logic pv, input logic [9:0] x, input logic [9:0] y,
                      input logic [7:0] ch, input logic [7:0] attr,
                      input logic [31:0] ec, input string tag);
    logic        v;
    logic [31:0] c;
    pix_valid = pv;
    x_pixel   = x;
    y_pixel   = y;
    cur_char  = ch;
    cur_attr  = attr;
    @(posedge clk); #1;
    exp_v_q.push_back(pv);
    exp_q.push_back(ec);
    v = exp_v_q.pop_front();
    c = exp_q.pop_front();
    if (v) hold_color = c;
    check({tag, " out_valid"}, 32'(out_valid), 32'(v));
    check({tag, " rgba_out"}, rgba_out, hold_color);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 10'd0, 10'd0, 8'h00, 8'h00, 32'h0, tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset rgba_out", rgba_out, 32'h0);
    reset = 1'b0;
    sb_reset();

    // palette setup while no pixels flow
    pal_we = 1'b1; pal_addr = 4'd2; pal_data = C2;
    idle("pal2");
    pal_addr = 4'd3; pal_data = C3;
    idle("pal3");
    pal_we = 1'b0;

    // main function: glyph bits, fg/bg selection, row rotation, gx=7 LSB
    step(1'b1, 10'd0,  10'd0,  8'h41, 8'h10, TXT, "clear_bit_bg1");
    step(1'b1, 10'd1,  10'd0,  8'h41, 8'h01, TXT, "set_bit_fg1");
    step(1'b1, 10'd1,  10'd0,  8'h41, 8'h10, BKG, "set_bit_fg0");
    step(1'b1, 10'd0,  10'd1,  8'h41, 8'h23, C3,  "row1_gx0");
    step(1'b1, 10'd10, 10'd0,  8'h41, 8'h21, C2,  "gx2_clear_bg2");
    step(1'b1, 10'd3,  10'd0,  8'h00, 8'h72, TXT, "blank_bg7");
    step(1'b1, 10'd5,  10'd0,  8'hFF, 8'h03, C3,  "solid_fg3");
    step(1'b1, 10'd15, 10'd2,  8'h41, 8'h02, C2,  "gx7_row2");
    step(1'b1, 10'd0,  10'd15, 8'h41, 8'h02, C2,  "row15_gx0");
    step(1'b1, 10'd8,  10'd16, 8'h41, 8'h30, C3,  "next_cell_clear");

    // valid toggling: output holds during gaps
    step(1'b1, 10'd0, 10'd0, 8'hFF, 8'h02, C2,  "tog1");
    step(1'b0, 10'd0, 10'd0, 8'hFF, 8'h03, 32'h0, "tog0a");
    step(1'b1, 10'd0, 10'd0, 8'h00, 8'h30, C3,  "tog1b");
    step(1'b0, 10'd0, 10'd0, 8'hFF, 8'h01, 32'h0, "tog0b");
    idle("flush_a"); idle("flush_b"); idle("flush_c");

    // palette write collides with a pixel in S3
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, TXT, "pal_old");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, RED, "pal_new");
    pal_we = 1'b1; pal_addr = 4'd1; pal_data = RED;
    idle("pal_wr");
    pal_we = 1'b0;
    idle("pal_flush_a"); idle("pal_flush_b");

    // blink: counter reaches 16 on the 16th pulse
    refresh = 1'b1;
    for (int i = 0; i < 15; i++) idle("refresh_a");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h81, RED, "blink_same_cycle");
    refresh = 1'b0;
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h81, BKG, "blink_on_set");
    step(1'b1, 10'd0, 10'd0, 8'h41, 8'h81, BKG, "blink_on_clear");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, RED, "noblink_attr");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h85, BKG, "blink_fg5");
    refresh = 1'b1;
    for (int i = 0; i < 16; i++) idle("refresh_b");
    refresh = 1'b0;
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h81, RED, "blink_off_again");
    idle("blink_flush_a"); idle("blink_flush_b");

    // reset mid-stream with pixels in flight
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, RED, "inflight_a");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, RED, "inflight_b");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, RED, "inflight_c");
    pix_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'h0);
    check("midreset rgba_out", rgba_out, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb_reset();
    idle("post_reset_a"); idle("post_reset_b"); idle("post_reset_c");
    step(1'b1, 10'd1, 10'd0, 8'h41, 8'h01, TXT, "post_reset_pix");
    idle("post_flush_a"); idle("post_flush_b");

`ifdef TEXT_CURSOR_EN
    refresh = 1'b1;
    for (int i = 0; i < 16; i++) idle("refresh_c");
    refresh = 1'b0;
    cursor_on = 1'b1; cursor_col = 7'd2; cursor_row = 6'd1;
    step(1'b1, 10'd16, 10'd16, 8'h80, 8'h01, BKG, "cursor_swap");
    cursor_col = 7'd3;
    step(1'b1, 10'd16, 10'd16, 8'h80, 8'h01, TXT, "cursor_elsewhere");
    idle("cursor_flush_a"); idle("cursor_flush_b");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
